// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - sync, debounce, edge-detect and arbitrate four raw buttons into command pulses
// Optional AUTO_REPEAT_EN adds held-button auto-repeat on the dec and inc channels.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16,
  parameter int CNT_W           = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic btn_dec,
  input  logic btn_inc,
  input  logic btn_prev,
  input  logic btn_next,
  output logic dec,
  output logic inc,
  output logic prev,
  output logic next
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Channel order everywhere: 0=dec, 1=inc, 2=prev, 3=next.
  logic [3:0]       w_btn;
  logic [3:0]       r_s1;
  logic [3:0]       r_s2;
  logic [3:0]       r_stable;
  logic [3:0]       r_stable_d;
  logic [CNT_W-1:0] r_cnt [4];
  logic [3:0]       w_press;
  logic [3:0]       w_raise;
  logic [3:0]       r_out;

  assign w_btn = {btn_next, btn_prev, btn_inc, btn_dec};

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_s1       <= '0;
      r_s2       <= '0;
      r_stable   <= '0;
      r_stable_d <= '0;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      r_s1       <= w_btn;
      r_s2       <= r_s1;
      r_stable_d <= r_stable;
      for (int i = 0; i < 4; i++) begin
        if (r_s2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DB_LAST) begin
          r_stable[i] <= r_s2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_press = r_stable & ~r_stable_d;

`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_FIRST = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RPT_NEXT  = CNT_W'(REPEAT_PERIOD);

  logic [CNT_W-1:0] r_rcnt [2];
  logic [1:0]       r_rphase;
  logic [1:0]       w_rep_fire;

  // r_rcnt counts cycles since the last pulse; r_rphase marks that the initial delay is over.
  always_comb begin
    w_rep_fire = '0;
    for (int i = 0; i < 2; i++) begin
      w_rep_fire[i] = r_stable[i] & ~w_press[i] &
                      (r_rphase[i] ? (r_rcnt[i] == RPT_NEXT) : (r_rcnt[i] == RPT_FIRST));
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_rphase <= '0;
      for (int i = 0; i < 2; i++) r_rcnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!r_stable[i]) begin
          r_rcnt[i]   <= '0;
          r_rphase[i] <= 1'b0;
        end else if (w_press[i]) begin
          r_rcnt[i]   <= CNT_W'(1);
          r_rphase[i] <= 1'b0;
        end else if (w_rep_fire[i]) begin
          r_rcnt[i]   <= CNT_W'(1);
          r_rphase[i] <= 1'b1;
        end else begin
          r_rcnt[i] <= r_rcnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_raise = w_press | {2'b00, w_rep_fire};
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (REPEAT_DELAY > 0) ^ (REPEAT_PERIOD > 0);
  assign w_raise      = w_press;
`endif

  // Opposing commands raised together cancel each other; nothing is deferred.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_out <= '0;
    end else begin
      r_out[0] <= w_raise[0] & ~w_raise[1];
      r_out[1] <= w_raise[1] & ~w_raise[0];
      r_out[2] <= w_raise[2] & ~w_raise[3];
      r_out[3] <= w_raise[3] & ~w_raise[2];
    end
  end

  assign dec  = r_out[0];
  assign inc  = r_out[1];
  assign prev = r_out[2];
  assign next = r_out[3];

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - self-checking bench for button_conditioner (honours AUTO_REPEAT_EN)
module tb_button_conditioner;

  localparam int D  = 16;
  localparam int RD = 64;
  localparam int RP = 16;
`ifdef AUTO_REPEAT_EN
  localparam int REP = 1;
`else
  localparam int REP = 0;
`endif

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic btn_dec = 1'b0, btn_inc = 1'b0, btn_prev = 1'b0, btn_next = 1'b0;
  logic dec, inc, prev, next;

  always #5 clock = ~clock;

  button_conditioner #(
    .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .CNT_W(16)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .btn_dec(btn_dec), .btn_inc(btn_inc), .btn_prev(btn_prev), .btn_next(btn_next),
    .dec(dec), .inc(inc), .prev(prev), .next(next)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit started = 0;
  logic [3:0] exp_out = '0;
  int cnt_p [4];
  int plog [4][256];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Reference: a level is accepted after D consecutive disagreeing samples of the
  // twice-delayed button; a rise yields a command one cycle later; repeats follow
  // at fixed offsets from that command while the level stays accepted.
  initial begin : model
    logic [3:0] d1, d2, st, pend, raise, btn;
    int run [4];
    int lp [4];
    bit lpv [4];
    int k;
    d1 = '0; d2 = '0; st = '0; pend = '0;
    for (int c = 0; c < 4; c++) begin run[c] = 0; lp[c] = 0; lpv[c] = 0; end
    forever begin
      @(posedge clock);
      cyc++;
      btn = {btn_next, btn_prev, btn_inc, btn_dec};
      if (!reset_n) begin
        d1 = '0; d2 = '0; st = '0; pend = '0;
        for (int c = 0; c < 4; c++) begin run[c] = 0; lpv[c] = 0; end
        exp_out = '0;
      end else begin
        for (int c = 0; c < 4; c++) begin
          raise[c] = pend[c];
          if (REP != 0 && c < 2 && lpv[c] && st[c] && !pend[c]) begin
            k = cyc - lp[c];
            if (k == RD || (k > RD && (k - RD) % RP == 0)) raise[c] = 1'b1;
          end
          if (pend[c]) begin lp[c] = cyc; lpv[c] = 1; end
          if (!st[c]) lpv[c] = 0;
          pend[c] = 1'b0;
          if (d2[c] != st[c]) begin
            run[c]++;
            if (run[c] == D) begin
              st[c]   = d2[c];
              run[c]  = 0;
              pend[c] = st[c];
            end
          end else begin
            run[c] = 0;
          end
        end
        d2 = d1;
        d1 = btn;
        exp_out = {raise[3] & ~raise[2], raise[2] & ~raise[3],
                   raise[1] & ~raise[0], raise[0] & ~raise[1]};
      end
      started = 1;
    end
  end

  initial begin : compare
    logic [3:0] act;
    for (int c = 0; c < 4; c++) cnt_p[c] = 0;
    forever begin
      @(negedge clock);
      if (started) begin
        act = {next, prev, inc, dec};
        checks++;
        if (act !== exp_out) begin
          failures++;
          $display("FAIL outputs cyc=%0d actual=%b required=%b", cyc, act, exp_out);
        end
        for (int c = 0; c < 4; c++) begin
          if (act[c] === 1'b1) begin
            if (cnt_p[c] < 256) plog[c][cnt_p[c]] = cyc;
            cnt_p[c]++;
          end
        end
      end
    end
  end

  initial begin : stim
    int s, b, b2, l, r, others;
    int hold [4];
    logic [3:0] lvl;

    step(3);
    chk("reset_state", int'({next, prev, inc, dec}), 0);
    reset_n = 1'b1;
    step(5);

    // Clean press with literal latency
    s = cyc; b = cnt_p[1]; others = cnt_p[0] + cnt_p[2] + cnt_p[3];
    btn_inc = 1'b1; step(100); btn_inc = 1'b0; step(40);
    chk("t1_count", cnt_p[1] - b, (REP != 0) ? 4 : 1);
    chk("t1_latency", plog[1][b] - s, 3 + D);
    chk("t1_others", cnt_p[0] + cnt_p[2] + cnt_p[3], others);

    // Bounce: 13 toggles three cycles apart, ending high
    b = cnt_p[0]; l = cyc;
    for (int t = 0; t < 13; t++) begin
      btn_dec = ~btn_dec; l = cyc; step(3);
    end
    step(40); btn_dec = 1'b0; step(40);
    chk("t2_count", cnt_p[0] - b, 1);
    chk("t2_latency", plog[0][b] - l, 3 + D);

    // Conflicts
    b = cnt_p[0]; b2 = cnt_p[1];
    btn_dec = 1'b1; btn_inc = 1'b1; step(60); btn_dec = 1'b0; btn_inc = 1'b0; step(40);
    chk("t3_dec_inc_suppressed", (cnt_p[0] - b) + (cnt_p[1] - b2), 0);
    b = cnt_p[2]; b2 = cnt_p[3];
    btn_prev = 1'b1; btn_next = 1'b1; step(60); btn_prev = 1'b0; btn_next = 1'b0; step(40);
    chk("t3_prev_next_suppressed", (cnt_p[2] - b) + (cnt_p[3] - b2), 0);
    b = cnt_p[1]; b2 = cnt_p[3];
    btn_inc = 1'b1; btn_next = 1'b1; step(50); btn_inc = 1'b0; btn_next = 1'b0; step(40);
    chk("t3_inc_count", cnt_p[1] - b, 1);
    chk("t3_next_count", cnt_p[3] - b2, 1);
    chk("t3_same_cycle", plog[1][b] - plog[3][b2], 0);

    // Reset in the middle of a debounce
    b = cnt_p[2];
    btn_prev = 1'b1; step(9);
    reset_n = 1'b0; step(2);
    reset_n = 1'b1; r = cyc;
    step(60); btn_prev = 1'b0; step(40);
    chk("t4_count", cnt_p[2] - b, 1);
    chk("t4_latency", plog[2][b] - r, 3 + D);

    // Release and re-press
    b = cnt_p[3];
    btn_next = 1'b1; step(40); btn_next = 1'b0; step(20);
    btn_next = 1'b1; step(40); btn_next = 1'b0; step(40);
    chk("t5_count", cnt_p[3] - b, 2);
    chk("t5_spacing", plog[3][b + 1] - plog[3][b], 60);

    // Long hold: auto-repeat when enabled
    s = cyc; b = cnt_p[1];
    btn_inc = 1'b1; step(200); btn_inc = 1'b0; step(50);
    chk("t6_count", cnt_p[1] - b, (REP != 0) ? 10 : 1);
    chk("t6_first", plog[1][b] - s, 3 + D);
    chk("t6_last", plog[1][b + ((cnt_p[1] - b > 0) ? cnt_p[1] - b - 1 : 0)] - s,
        (REP != 0) ? 211 : 19);

    // Randomised mixture of bounces, holds, overlaps and resets
    for (int c = 0; c < 4; c++) hold[c] = 0;
    lvl = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < 4; c++) begin
        if (hold[c] == 0) begin
          lvl[c]  = ~lvl[c];
          hold[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(60, 200))
                                                : int'($urandom_range(1, 25));
        end
        hold[c]--;
      end
      {btn_next, btn_prev, btn_inc, btn_dec} = lvl;
      reset_n = ($urandom_range(0, 799) == 0) ? 1'b0 : 1'b1;
      step(1);
    end
    reset_n = 1'b1;
    {btn_next, btn_prev, btn_inc, btn_dec} = 4'b0000;
    step(60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
